// File: rtl/dct_pkg.sv
// Shared types, constants and the cosine-table math for the 8x8 DCT sequencer.
package dct_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam int N          = 8;
  localparam int Q_FRAC     = 8;
  localparam int PIX_OFFSET = 128;

  typedef logic signed [31:0] coef_t;
  typedef logic [2:0]         idx_t;

  // Q8 magnitude of cos(j*pi/16), truncated toward zero, for j = 0..8.
  function automatic int cos_base(input int j);
    case (j)
      0:       return 256;
      1:       return 251;
      2:       return 236;
      3:       return 212;
      4:       return 181;
      5:       return 142;
      6:       return 97;
      7:       return 49;
      default: return 0;
    endcase
  endfunction

  // Q8 cos((2n+1)*k*pi/16), folded onto the first quadrant by symmetry.
  function automatic int cos_q8(input int k, input int n);
    int m;
    m = ((2 * n + 1) * k) % 32;
    if (m > 16) m = 32 - m;
    if (m > 8) return -cos_base(16 - m);
    return cos_base(m);
  endfunction

  // Separable 2-D term, renormalised back to Q8.
  function automatic coef_t cos_2d(input int k1, input int k2, input int n1, input int n2);
    return coef_t'((cos_q8(k1, n1) * cos_q8(k2, n2)) >>> Q_FRAC);
  endfunction

endpackage

// File: rtl/dct_cos_lut.sv
// Combinational 2-D cosine table: one 64-entry row per (k1,k2), selected by {k1,k2}.
module dct_cos_lut
  import dct_pkg::*;
(
  input  logic [2:0]  k1,
  input  logic [2:0]  k2,
  input  logic [2:0]  n1,
  input  logic [2:0]  n2,
  output logic [31:0] cos_term
);

  logic [31:0] kk_term [N*N];

  for (genvar gi = 0; gi < N * N; gi++) begin : g_kk
    logic [31:0] row [N*N];
    for (genvar gj = 0; gj < N * N; gj++) begin : g_n
      localparam coef_t ENTRY = cos_2d(gi / N, gi % N, gj / N, gj % N);
      assign row[gj] = ENTRY;
    end
    assign kk_term[gi] = row[{n1, n2}];
  end

  assign cos_term = kk_term[{k1, k2}];

endmodule

// File: rtl/dct_2d_sequencer.sv
// Walks an 8x8 pixel block once per coefficient, accumulating the Q8 DCT sum and
// presenting each coefficient on a valid/ready port.
module dct_2d_sequencer
  import dct_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic [5:0]  pix_addr,
  input  logic [7:0]  pix_data,
  output logic [31:0] coef,
  output logic [5:0]  coef_k,
  output logic        coef_valid,
  input  logic        coef_ready,
  output logic        done
);

  state_e      state_q, state_d;
  logic [5:0]  k_q, k_d, n_q, n_d, n_dly_q;
  logic        rd_valid_q;
  coef_t       acc_q, acc_d, coef_q, coef_d;
  logic [5:0]  coef_k_q, coef_k_d;
  logic        coef_valid_q, coef_valid_d, done_q, done_d;
  idx_t        k1, k2, n1, n2;
  logic [31:0] cos_term;
  coef_t       pix_centered, product;

  // n_dly_q lines the table index up with the RAM's one-cycle read latency.
  assign k1 = k_q[5:3];
  assign k2 = k_q[2:0];
  assign n1 = n_dly_q[5:3];
  assign n2 = n_dly_q[2:0];

  dct_cos_lut u_lut (
    .k1       (k1),
    .k2       (k2),
    .n1       (n1),
    .n2       (n2),
    .cos_term (cos_term)
  );

  assign pix_centered = $signed({24'd0, pix_data}) - coef_t'(PIX_OFFSET);
  assign product      = pix_centered * $signed(cos_term);

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    n_d          = n_q;
    acc_d        = acc_q;
    coef_d       = coef_q;
    coef_k_d     = coef_k_q;
    coef_valid_d = coef_valid_q;
    done_d       = 1'b0;
    if (rd_valid_q) acc_d = acc_q + product;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = '0;
          n_d     = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        n_d = n_q + 6'd1;
        if (n_q == 6'd63) state_d = DRAIN;
      end
      DRAIN: begin
        // Leave only once the last product has landed in acc_q.
        if (!rd_valid_q) begin
          coef_d       = acc_q >>> Q_FRAC;
          coef_k_d     = k_q;
          coef_valid_d = 1'b1;
          state_d      = OUT;
        end
      end
      OUT: begin
        if (coef_ready) begin
          coef_valid_d = 1'b0;
          if (k_q == 6'd63) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            k_d     = k_q + 6'd1;
            n_d     = '0;
            acc_d   = '0;
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      k_q          <= '0;
      n_q          <= '0;
      n_dly_q      <= '0;
      rd_valid_q   <= 1'b0;
      acc_q        <= '0;
      coef_q       <= '0;
      coef_k_q     <= '0;
      coef_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      n_q          <= n_d;
      n_dly_q      <= n_q;
      rd_valid_q   <= (state_q == RUN);
      acc_q        <= acc_d;
      coef_q       <= coef_d;
      coef_k_q     <= coef_k_d;
      coef_valid_q <= coef_valid_d;
      done_q       <= done_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign pix_addr   = (state_q == RUN) ? n_q : 6'd0;
  assign coef       = coef_q;
  assign coef_k     = coef_k_q;
  assign coef_valid = coef_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_dct_2d_sequencer.sv
// Scoreboard bench for dct_2d_sequencer: a real-valued DCT model feeds an expected queue
// that an independent monitor drains on every coefficient handshake.
module tb_dct_2d_sequencer;

  localparam real PI = 3.14159265358979;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic [5:0]  pix_addr;
  logic [7:0]  pix_data = 8'd0;
  logic [31:0] coef;
  logic [5:0]  coef_k;
  logic        coef_valid;
  logic        coef_ready = 1'b1;
  logic        done;

  dct_2d_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .pix_addr   (pix_addr),
    .pix_data   (pix_data),
    .coef       (coef),
    .coef_k     (coef_k),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [7:0] pix_mem [64];
  always @(posedge clk) pix_data <= pix_mem[pix_addr];

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int k; int val; } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int ref_edge = 0;
  bit timing_armed = 0;
  bit spot_en = 0;
  int spot_k = 24;
  int spot_val = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference cosine straight from the definition, truncated toward zero.
  function automatic int cq8(input int k, input int n);
    real a;
    a = real'((2 * n + 1) * k) * PI / 16.0;
    return $rtoi(256.0 * $cos(a));
  endfunction

  function automatic int model_coef(input int kk);
    int acc;
    int ct;
    acc = 0;
    for (int n = 0; n < 64; n++) begin
      ct  = (cq8(kk / 8, n / 8) * cq8(kk % 8, n % 8)) >>> 8;
      acc = acc + (int'(pix_mem[n]) - 128) * ct;
    end
    return acc >>> 8;
  endfunction

  // Monitor: handshakes, latency, hold-while-stalled, done pulse.
  bit          prev_stall = 0;
  bit          prev_valid = 0;
  bit          exp_done = 0;
  logic [31:0] held_coef;
  logic [5:0]  held_k;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall   = 0;
      prev_valid   = 0;
      exp_done     = 0;
      timing_armed = 0;
    end else begin
      if (done || exp_done) begin
        check("done_pulse", done, exp_done);
        if (exp_done) check("busy_at_done", busy, 0);
      end
      exp_done = 0;
      if (coef_valid && !prev_valid) begin
        if (timing_armed) check("valid_latency", cyc - ref_edge, 66);
        else check("valid_without_start", coef_valid, 0);
        timing_armed = 0;
      end
      if (prev_stall) begin
        check("hold_coef", coef, held_coef);
        check("hold_k", coef_k, held_k);
        check("hold_valid", coef_valid, 1);
      end
      prev_stall = coef_valid && !coef_ready;
      held_coef  = coef;
      held_k     = coef_k;
      if (coef_valid && coef_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_coef", coef_valid, 0);
        end else begin
          e = sb.pop_front();
          check("coef_k", coef_k, e.k);
          check("coef", $signed(coef), e.val);
          if (spot_en && e.k == spot_k) check("spot_coef", $signed(coef), spot_val);
          if (e.k == 63) exp_done = 1;
          else begin
            ref_edge     = cyc + 1;
            timing_armed = 1;
          end
        end
      end
      prev_valid = coef_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ready_mode: 0 = always ready, 1 = random backpressure.
  task automatic run_block(input int ready_mode, input int stall_k, input bit busy_start,
                           input int reset_k, input bit end_start);
    int guard;
    int stall_cnt;
    bit finished;
    exp_t e;
    for (int k = 0; k < 64; k++) begin
      e.k   = k;
      e.val = model_coef(k);
      sb.push_back(e);
    end
    start        = 1'b1;
    ref_edge     = cyc + 1;
    timing_armed = 1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    guard     = 0;
    stall_cnt = 0;
    finished  = 0;
    while (!finished && guard < 9000) begin
      start      = 1'b0;
      coef_ready = 1'b1;
      if (ready_mode == 1) coef_ready = ($urandom_range(0, 3) != 0);
      if (coef_valid && int'(coef_k) == stall_k && stall_cnt < 10) begin
        coef_ready = 1'b0;
        stall_cnt++;
      end
      if (end_start && coef_valid && coef_k == 6'd63) begin
        coef_ready = 1'b1;
        start      = 1'b1;
      end
      if (busy_start && guard == 500) start = 1'b1;
      if (reset_k >= 0 && sb.size() == 64 - reset_k && pix_addr == 6'd10) begin
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        sb.delete();
        check("rst_mid_busy", busy, 0);
        check("rst_mid_valid", coef_valid, 0);
        check("rst_mid_pix_addr", pix_addr, 0);
        finished = 1;
      end else begin
        tick();
        guard++;
        if (done) finished = 1;
      end
    end
    start      = 1'b0;
    coef_ready = 1'b1;
    check("block_finished", finished, 1);
    repeat (4) tick();
    check("idle_busy", busy, 0);
    check("idle_valid", coef_valid, 0);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) pix_mem[i] = 8'd128;
    repeat (3) tick();
    rst_n = 1'b1;
    check("reset_busy", busy, 0);
    check("reset_valid", coef_valid, 0);
    check("reset_done", done, 0);
    check("reset_coef", coef, 0);
    check("reset_coef_k", coef_k, 0);
    check("reset_pix_addr", pix_addr, 0);
    tick();

    // Flat mid-grey block: every coefficient is zero.
    run_block(0, -1, 0, -1, 0);

    // Single bright pixel at {0,0}.
    pix_mem[0] = 8'd255;
    spot_en    = 1;
    spot_val   = 105;
    run_block(0, -1, 0, -1, 0);

    // Flat white block: the k={3,0} column terms cancel.
    for (int i = 0; i < 64; i++) pix_mem[i] = 8'd255;
    spot_val = 0;
    run_block(0, -1, 0, -1, 0);
    spot_en = 0;

    // Random block, 10-cycle stall on k=5, stray start while busy.
    for (int i = 0; i < 64; i++) pix_mem[i] = 8'($urandom_range(0, 255));
    run_block(0, 5, 1, -1, 0);

    // Random block aborted by reset during k=20.
    for (int i = 0; i < 64; i++) pix_mem[i] = 8'($urandom_range(0, 255));
    run_block(1, -1, 0, 20, 0);

    // Fresh random block after the abort, start coincident with the final handshake.
    for (int i = 0; i < 64; i++) pix_mem[i] = 8'($urandom_range(0, 255));
    run_block(1, -1, 0, -1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
